// File: rtl/hw_barrier_multi_pkg.sv
// Shared register map, barrier-id width helper and per-barrier state for the
// multi-barrier unit.
package hw_barrier_multi_pkg;

   typedef enum logic [2:0] {
      OFF_TRIG_MASK     = 3'd0,
      OFF_STATUS        = 3'd1,
      OFF_TARGET_MASK   = 3'd2,
      OFF_SW_TRIGGER    = 3'd3,
      OFF_GEN_COUNT     = 3'd4,
      OFF_TIMEOUT_LIMIT = 3'd5,
      OFF_TIMEOUT_FLAG  = 3'd6,
      OFF_RSVD          = 3'd7
   } reg_off_e;

   localparam int unsigned MAX_CORES = 32;
   localparam int unsigned GEN_W     = 16;

   function automatic int unsigned barr_id_w(input int unsigned nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

   typedef struct packed {
      logic [MAX_CORES-1:0] trig_mask;
      logic [MAX_CORES-1:0] status;
      logic [MAX_CORES-1:0] target_mask;
      logic [GEN_W-1:0]     gen_count;
   } barrier_state_t;

endpackage

// File: rtl/hw_barrier_slice.sv
// One barrier: registers, match detection and (with HWBARR_TIMEOUT_EN) the
// arrival timeout counter.
module hw_barrier_slice
   import hw_barrier_multi_pkg::*;
#(
   parameter int unsigned NB_CORES  = 8,
   parameter int unsigned TIMEOUT_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NB_CORES-1:0] hw_arrive_i,
   input  logic                we_i,
   input  reg_off_e            off_i,
   input  logic [31:0]         wdata_i,
   output logic                match_o,
   output logic [NB_CORES-1:0] target_o,
   output logic [NB_CORES-1:0] status_o,
   output logic [31:0]         rdata_o,
   output logic                timeout_flag_o
);

   localparam logic [MAX_CORES-1:0] CORE_MSK = MAX_CORES'((64'd1 << NB_CORES) - 64'd1);

   barrier_state_t       st_q;
   logic [MAX_CORES-1:0] wmask;
   logic [MAX_CORES-1:0] arrive;
   logic                 mask_we;
   logic [31:0]          lim_rd;

   always_comb begin
      wmask   = wdata_i & CORE_MSK;
      mask_we = we_i && (off_i == OFF_TRIG_MASK);
      arrive  = MAX_CORES'(hw_arrive_i);
      if (we_i && (off_i == OFF_SW_TRIGGER)) arrive = arrive | wmask;
   end

   assign match_o = (st_q.trig_mask != '0) && (st_q.status == st_q.trig_mask);

   // Mask write wins over arrivals; a match hands same-cycle arrivals to the next round.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q <= '0;
      end else begin
         if (mask_we) st_q.trig_mask <= wmask;
         if (we_i && (off_i == OFF_TARGET_MASK)) st_q.target_mask <= wmask;
         if (mask_we)      st_q.status <= '0;
         else if (match_o) st_q.status <= arrive;
         else              st_q.status <= st_q.status | arrive;
         if (match_o) st_q.gen_count <= st_q.gen_count + 1'b1;
      end
   end

`ifdef HWBARR_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_lim_q, tmo_nxt;
   logic                 tmo_flag_q, counting, tmo_step;

   assign counting = !mask_we && !match_o && (st_q.status != '0);
   assign tmo_nxt  = tmo_cnt_q + 1'b1;
   assign tmo_step = counting && (tmo_cnt_q != tmo_lim_q);

   // Flag is set only on the step that reaches the limit, so a W1C sticks
   // while the counter sits saturated.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q  <= '0;
         tmo_lim_q  <= '1;
         tmo_flag_q <= 1'b0;
      end else begin
         if (we_i && (off_i == OFF_TIMEOUT_LIMIT)) tmo_lim_q <= TIMEOUT_W'(wdata_i);
         if (mask_we || match_o) tmo_cnt_q <= '0;
         else if (tmo_step)      tmo_cnt_q <= tmo_nxt;
         if (tmo_step && (tmo_nxt == tmo_lim_q))                       tmo_flag_q <= 1'b1;
         else if (we_i && (off_i == OFF_TIMEOUT_FLAG) && wdata_i[0])   tmo_flag_q <= 1'b0;
      end
   end

   assign lim_rd         = 32'(tmo_lim_q);
   assign timeout_flag_o = tmo_flag_q;
`else
   logic [TIMEOUT_W-1:0] unused_tmo;
   assign unused_tmo     = '0;
   assign lim_rd         = '0;
   assign timeout_flag_o = 1'b0;
`endif

   always_comb begin
      rdata_o = '0;
      case (off_i)
         OFF_TRIG_MASK:     rdata_o = st_q.trig_mask;
         OFF_STATUS:        rdata_o = st_q.status;
         OFF_TARGET_MASK:   rdata_o = st_q.target_mask;
         OFF_GEN_COUNT:     rdata_o = 32'(st_q.gen_count);
         OFF_TIMEOUT_LIMIT: rdata_o = lim_rd;
         OFF_TIMEOUT_FLAG:  rdata_o = {31'b0, timeout_flag_o};
         default:           rdata_o = '0;
      endcase
   end

   assign target_o = st_q.target_mask[NB_CORES-1:0];
   assign status_o = st_q.status[NB_CORES-1:0];

endmodule

// File: rtl/hw_barrier_multi_unit.sv
// Multi-barrier synchronisation unit: trigger decode, register decode/read mux
// and NB_BARRIERS slices. Optional timeouts via HWBARR_TIMEOUT_EN.
module hw_barrier_multi_unit
   import hw_barrier_multi_pkg::*;
#(
   parameter  int unsigned NB_CORES    = 8,
   parameter  int unsigned NB_BARRIERS = 8,
   parameter  int unsigned TIMEOUT_W   = 16,
   localparam int unsigned BARR_ID_W   = barr_id_w(NB_BARRIERS)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NB_CORES-1:0]                    trig_valid_i,
   input  logic [NB_CORES-1:0][BARR_ID_W-1:0]     trig_id_i,
   input  logic                                   req_i,
   input  logic [31:0]                            add_i,
   input  logic                                   wen_i,
   input  logic [31:0]                            wdata_i,
   output logic                                   gnt_o,
   output logic                                   r_valid_o,
   output logic [31:0]                            r_rdata_o,
   output logic [NB_CORES-1:0]                    barrier_events_o,
   output logic [NB_BARRIERS-1:0][NB_CORES-1:0]   barrier_status_o,
   output logic                                   timeout_irq_o
);

   logic [BARR_ID_W-1:0]  bidx;
   logic                  in_range, wr_en, unused_add;
   reg_off_e              off;
   logic [NB_CORES-1:0]   hw_arr   [NB_BARRIERS];
   logic [NB_CORES-1:0]   target   [NB_BARRIERS];
   logic [31:0]           rdata    [NB_BARRIERS];
   logic [NB_BARRIERS-1:0] match, tmo_flag;

   // Range check uses every bit above the offset so aliased ids are rejected.
   assign in_range   = add_i[31:5] < 27'(NB_BARRIERS);
   assign bidx       = add_i[5+BARR_ID_W-1:5];
   assign off        = reg_off_e'(add_i[4:2]);
   assign wr_en      = req_i && !wen_i && in_range;
   assign unused_add = ^add_i[1:0];
   assign gnt_o      = req_i;

   always_comb begin
      for (int unsigned b = 0; b < NB_BARRIERS; b++) begin
         hw_arr[b] = '0;
         for (int unsigned c = 0; c < NB_CORES; c++)
            if (trig_valid_i[c] && (trig_id_i[c] == BARR_ID_W'(b))) hw_arr[b][c] = 1'b1;
      end
   end

   for (genvar g = 0; g < NB_BARRIERS; g++) begin : g_slice
      hw_barrier_slice #(
         .NB_CORES  (NB_CORES),
         .TIMEOUT_W (TIMEOUT_W)
      ) u_slice (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .hw_arrive_i    (hw_arr[g]),
         .we_i           (wr_en && (bidx == BARR_ID_W'(g))),
         .off_i          (off),
         .wdata_i        (wdata_i),
         .match_o        (match[g]),
         .target_o       (target[g]),
         .status_o       (barrier_status_o[g]),
         .rdata_o        (rdata[g]),
         .timeout_flag_o (tmo_flag[g])
      );
   end

   always_comb begin
      barrier_events_o = '0;
      for (int unsigned b = 0; b < NB_BARRIERS; b++)
         if (match[b]) barrier_events_o = barrier_events_o | target[b];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid_o <= 1'b0;
         r_rdata_o <= '0;
      end else begin
         r_valid_o <= req_i;
         r_rdata_o <= (req_i && wen_i && in_range) ? rdata[bidx] : '0;
      end
   end

   assign timeout_irq_o = |tmo_flag;

endmodule

// File: tb/tb_hw_barrier_multi_unit.sv
// Scoreboard bench for hw_barrier_multi_unit: directed scenarios then random
// traffic against an array-based reference model.
module tb_hw_barrier_multi_unit;
   import hw_barrier_multi_pkg::*;

   localparam int unsigned NC = 8;
   localparam int unsigned NB = 8;
   localparam int unsigned TW = 16;
   localparam int unsigned BW = barr_id_w(NB);

   logic                     clk_i = 1'b0;
   logic                     rst_ni = 1'b0;
   logic [NC-1:0]            trig_valid_i = '0;
   logic [NC-1:0][BW-1:0]    trig_id_i = '0;
   logic                     req_i = 1'b0;
   logic [31:0]              add_i = '0;
   logic                     wen_i = 1'b1;
   logic [31:0]              wdata_i = '0;
   logic                     gnt_o, r_valid_o, timeout_irq_o;
   logic [31:0]              r_rdata_o;
   logic [NC-1:0]            barrier_events_o;
   logic [NB-1:0][NC-1:0]    barrier_status_o;

   hw_barrier_multi_unit #(.NB_CORES(NC), .NB_BARRIERS(NB), .TIMEOUT_W(TW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .trig_valid_i(trig_valid_i), .trig_id_i(trig_id_i),
      .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
      .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .barrier_events_o(barrier_events_o),
      .barrier_status_o(barrier_status_o), .timeout_irq_o(timeout_irq_o));

   always #5 clk_i = ~clk_i;

   int n_chk = 0, n_fail = 0, cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct { int due; logic [31:0] data; } rsp_t;
   rsp_t sbq[$];
   rsp_t mon_e;

   // Reference model state
   logic [NC-1:0] m_tm [NB], m_tg [NB], m_st [NB];
   logic [15:0]   m_gen [NB];
   logic [TW-1:0] m_cnt [NB], m_lim [NB];
   bit            m_flag [NB];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int b = 0; b < NB; b++) begin
         m_tm[b] = '0; m_tg[b] = '0; m_st[b] = '0; m_gen[b] = '0;
         m_cnt[b] = '0; m_lim[b] = '1; m_flag[b] = 0;
      end
   endfunction

   function automatic logic [31:0] m_read(int b, int off);
      if (b >= NB) return 32'd0;
      case (off)
         0: return 32'(m_tm[b]);
         1: return 32'(m_st[b]);
         2: return 32'(m_tg[b]);
         4: return 32'(m_gen[b]);
`ifdef HWBARR_TIMEOUT_EN
         5: return 32'(m_lim[b]);
         6: return 32'(m_flag[b]);
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit m_match(int b);
      return (m_tm[b] != 0) && (m_st[b] == m_tm[b]);
   endfunction

   task automatic chk_outputs();
      logic [NC-1:0] ev = '0;
      logic [NB-1:0][NC-1:0] es;
      bit irq = 0;
      for (int b = 0; b < NB; b++) begin
         if (m_match(b)) ev |= m_tg[b];
         es[b] = m_st[b];
         irq |= m_flag[b];
      end
      chk("events", barrier_events_o, ev);
      chk("status", barrier_status_o, es);
      chk("irq", timeout_irq_o, irq);
   endtask

   task automatic model_step(input logic [NC-1:0] tv, input logic [NC-1:0][BW-1:0] tid,
                             input logic rq, input logic [31:0] ad, input logic rd, input logic [31:0] wd);
      int b = int'(ad >> 5);
      int off = int'(ad[4:2]);
      bit wr = rq && !rd && (b < NB);
      logic [NC-1:0] arr [NB];
      bit mt [NB];
      if (rq) sbq.push_back('{cyc + 1, rd ? m_read(b, off) : 32'd0});
      for (int i = 0; i < NB; i++) begin
         mt[i] = m_match(i);
         arr[i] = '0;
      end
      for (int c = 0; c < NC; c++)
         if (tv[c] && (int'(tid[c]) < NB)) arr[tid[c]][c] = 1'b1;
      if (wr && off == 3) arr[b] |= wd[NC-1:0];
      for (int i = 0; i < NB; i++) begin
         bit sel = wr && (b == i);
         bit mw = sel && (off == 0);
`ifdef HWBARR_TIMEOUT_EN
         bit set = 0;
         if (mw || mt[i]) m_cnt[i] = '0;
         else if (m_st[i] != 0 && m_cnt[i] != m_lim[i]) begin
            m_cnt[i] = m_cnt[i] + 1'b1;
            set = (m_cnt[i] == m_lim[i]);
         end
         if (set) m_flag[i] = 1;
         else if (sel && off == 6 && wd[0]) m_flag[i] = 0;
         if (sel && off == 5) m_lim[i] = wd[TW-1:0];
`endif
         if (mw)         m_st[i] = '0;
         else if (mt[i]) m_st[i] = arr[i];
         else            m_st[i] = m_st[i] | arr[i];
         if (mt[i]) m_gen[i] = m_gen[i] + 16'd1;
         if (mw) m_tm[i] = wd[NC-1:0];
         if (sel && off == 2) m_tg[i] = wd[NC-1:0];
      end
   endtask

   // Drive one cycle from a negedge, advance the model, land on the next negedge.
   task automatic tick(input logic [NC-1:0] tv, input logic [NC-1:0][BW-1:0] tid,
                       input logic rq, input logic [31:0] ad, input logic rd, input logic [31:0] wd);
      trig_valid_i = tv; trig_id_i = tid; req_i = rq; add_i = ad; wen_i = rd; wdata_i = wd;
      #1;
      chk("gnt", gnt_o, rq);
      model_step(tv, tid, rq, ad, rd, wd);
      @(negedge clk_i);
      chk_outputs();
   endtask

   function automatic logic [31:0] addr(int b, int off);
      return (32'(b) << 5) | (32'(off) << 2);
   endfunction

   task automatic idle(int n);
      repeat (n) tick('0, '0, 1'b0, 32'd0, 1'b1, 32'd0);
   endtask
   task automatic wr(int b, int off, logic [31:0] d);
      tick('0, '0, 1'b1, addr(b, off), 1'b0, d);
   endtask
   task automatic rd(int b, int off);
      tick('0, '0, 1'b1, addr(b, off), 1'b1, 32'd0);
   endtask
   task automatic trig(int core, int id);
      logic [NC-1:0][BW-1:0] t = '0;
      t[core] = BW'(id);
      tick(NC'(1) << core, t, 1'b0, 32'd0, 1'b1, 32'd0);
   endtask

   always @(negedge clk_i) begin
      if (r_valid_o) begin
         if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_unexpected: got r_valid=1 expected no response (t=%0t)", $time);
         end else begin
            mon_e = sbq.pop_front();
            chk("rsp_cycle", 512'(cyc), 512'(mon_e.due));
            chk("rdata", r_rdata_o, mon_e.data);
         end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
         n_chk++; n_fail++;
         $display("FAIL rsp_missing: got r_valid=0 expected response due cycle %0d", sbq[0].due);
         void'(sbq.pop_front());
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [NC-1:0][BW-1:0] t;
      int n;
      model_reset();
      repeat (2) @(negedge clk_i);
      chk_outputs();
      chk("rst_rvalid", r_valid_o, 1'b0);
      chk("rst_rdata", r_rdata_o, 32'd0);
      rst_ni = 1'b1;
      rd(0, 5);

      // Single barrier round and generation count
      wr(2, 0, 32'h0F); wr(2, 2, 32'hF0);
      for (int c = 0; c < 4; c++) trig(c, 2);
      chk("evt_round1", barrier_events_o, 8'hF0);
      idle(1);
      chk("evt_pulse_end", barrier_events_o, 8'h00);
      chk("status2_cleared", barrier_status_o[2], 8'h00);
      rd(2, 4);

      // Arrival in the match cycle carries into the next round
      trig(1, 2); trig(2, 2); trig(3, 2); trig(0, 2);
      trig(0, 2);
      chk("status2_carry", barrier_status_o[2], 8'h01);
      trig(1, 2); trig(2, 2); trig(3, 2);
      chk("evt_round3", barrier_events_o, 8'hF0);
      idle(1);
      rd(2, 4); rd(2, 1);

      // Two barriers completing together merge their targets
      wr(0, 0, 32'h03); wr(0, 2, 32'h03); wr(1, 0, 32'h0C); wr(1, 2, 32'h0C);
      t = '0; t[2] = BW'(1); t[3] = BW'(1);
      tick(8'h0F, t, 1'b0, 32'd0, 1'b1, 32'd0);
      chk("evt_merge", barrier_events_o, 8'h0F);
      idle(1);

      // Mask write overrides a concurrent arrival
      wr(4, 0, 32'h03); trig(0, 4);
      t = '0; t[1] = BW'(4);
      tick(8'h02, t, 1'b1, addr(4, 0), 1'b0, 32'h03);
      chk("mask_wr_clears", barrier_status_o[4], 8'h00);

      // Out-of-range barrier: reads 0, writes ignored; software trigger
      rd(9, 4); wr(9, 0, 32'hFF); rd(9, 0); wr(8, 2, 32'hFF);
      wr(5, 0, 32'h81); wr(5, 2, 32'h11); wr(5, 3, 32'h81); idle(1); rd(5, 4);

`ifdef HWBARR_TIMEOUT_EN
      wr(3, 5, 32'd10); wr(3, 0, 32'h03); trig(0, 3);
      n = 0;
      while (!timeout_irq_o && n < 20) begin idle(1); n++; end
      chk("tmo_latency", n, 10);
      wr(3, 6, 32'd1);
      chk("tmo_w1c", timeout_irq_o, 1'b0);
      idle(3); rd(3, 6);
`else
      wr(3, 5, 32'd10); wr(3, 6, 32'd1); rd(3, 5); rd(3, 6);
      n = 0;
      chk("tmo_disabled_irq", timeout_irq_o, 1'b0);
`endif

      // Reset mid-round discards arrivals
      trig(1, 2); trig(2, 2); trig(3, 2);
      rst_ni = 1'b0; req_i = 1'b0; trig_valid_i = '0;
      model_reset();
      #1;
      chk_outputs();
      chk("rst_mid_status", barrier_status_o[2], 8'h00);
      @(negedge clk_i);
      rst_ni = 1'b1;
      rd(2, 0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         logic [NC-1:0] tv = NC'($urandom & $urandom & $urandom);
         logic rq = 0, rdn = 1;
         logic [31:0] ad = 0, wd = 0;
         for (int c = 0; c < NC; c++) t[c] = BW'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0 || i % 40 == 0) begin
            int b = $urandom_range(0, NB + 1);
            int off = (i % 40 == 0) ? 0 : $urandom_range(0, 7);
            rq = 1; rdn = $urandom_range(0, 1);
            if (i % 40 == 0) begin rdn = 0; b = $urandom_range(0, 3); end
            ad = addr(b, off) | 32'($urandom_range(0, 3));
            case (off)
               0, 2:    wd = (32'd1 << $urandom_range(0, NC - 1)) | (32'd1 << $urandom_range(0, NC - 1));
               5:       wd = $urandom_range(1, 40);
               default: wd = $urandom;
            endcase
         end
         tick(tv, t, rq, ad, rdn, wd);
      end
      for (int b = 0; b < NB + 2; b++) rd(b, 4);
      idle(3);
      chk("sb_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
